// File: rtl/vreg_group_scoreboard.sv
// Vector-register hazard scoreboard for LMUL register groups.
//
// Tracks, per architectural vector register, an outstanding-writer bit with
// the writer's instruction ID and a saturating count of outstanding readers.
// A combinational stall is raised for WAW, WAR, RAW and reader-count capacity
// hazards of the instruction currently presented on the iss_* port.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   iss_use_i               operand use flags {vs2, vs1, vd}
//   iss_vd_i/vs1_i/vs2_i    group base registers of the presented instruction
//   iss_emul_i              log2 group size, shared by all operands
//   iss_id_i                instruction ID recorded as the writer of vd
//   iss_fire_i              instruction issued this cycle, commit its update
//   rd_done_i, rd_vs_i,
//   rd_emul_i               per operand queue: release one read of a group
//   wr_done_i, wr_vd_i,
//   wr_emul_i, wr_id_i      per VFU: writeback of a group completed
//   flush_i                 synchronous clear of all tracking state
//   stall_o                 issue must not fire
//   stall_cause_o           {cnt_full, raw_vs2, raw_vs1, war, waw}
//   busy_o                  any register has a writer or readers outstanding
//   err_o                   sticky protocol error, cleared only by reset
module vreg_group_scoreboard #(
  parameter int NrVReg     = 32,
  parameter int NrVFU      = 4,
  parameter int NrOpQueue  = 4,
  parameter int ReaderCntW = 2,
  parameter int IdW        = 3,
  parameter int MaxEmulLog = 3,
  localparam int VregW     = $clog2(NrVReg),
  localparam int EmulW     = (MaxEmulLog > 0) ? $clog2(MaxEmulLog + 1) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [2:0]                           iss_use_i,
  input  logic [VregW-1:0]                     iss_vd_i,
  input  logic [VregW-1:0]                     iss_vs1_i,
  input  logic [VregW-1:0]                     iss_vs2_i,
  input  logic [EmulW-1:0]                     iss_emul_i,
  input  logic [IdW-1:0]                       iss_id_i,
  input  logic                                 iss_fire_i,
  input  logic [NrOpQueue-1:0]                 rd_done_i,
  input  logic [NrOpQueue-1:0][VregW-1:0]      rd_vs_i,
  input  logic [NrOpQueue-1:0][EmulW-1:0]      rd_emul_i,
  input  logic [NrVFU-1:0]                     wr_done_i,
  input  logic [NrVFU-1:0][VregW-1:0]          wr_vd_i,
  input  logic [NrVFU-1:0][EmulW-1:0]          wr_emul_i,
  input  logic [NrVFU-1:0][IdW-1:0]            wr_id_i,
  input  logic                                 flush_i,
  output logic                                 stall_o,
  output logic [4:0]                           stall_cause_o,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam int CntMax = (1 << ReaderCntW) - 1;

  // Registers base .. base+2^emul-1; anything past the last register is
  // dropped rather than wrapped, and oversized emul is clamped.
  function automatic logic [NrVReg-1:0] grp_mask(input logic [VregW-1:0] base,
                                                 input logic [EmulW-1:0] emul);
    logic [NrVReg-1:0] m;
    int e;
    int sz;
    e  = (int'(emul) > MaxEmulLog) ? MaxEmulLog : int'(emul);
    sz = 1 << e;
    m  = '0;
    for (int r = 0; r < NrVReg; r++) begin
      if (r >= int'(base) && r < int'(base) + sz) m[r] = 1'b1;
    end
    return m;
  endfunction

  logic [NrVReg-1:0]                 writing_q, writing_d;
  logic [NrVReg-1:0][IdW-1:0]        writer_id_q, writer_id_d;
  logic [NrVReg-1:0][ReaderCntW-1:0] readers_q, readers_d;
  logic                              err_q, err_d;

  logic [NrVReg-1:0]                 vd_m, vs1_m, vs2_m;
  logic [NrVReg-1:0]                 rd_nz, full_vec;
  logic [NrOpQueue-1:0][NrVReg-1:0]  rel_m;
  logic [NrVFU-1:0][NrVReg-1:0]      cpl_m;
  logic [4:0]                        cause;

  // Hazard evaluation looks only at registered state, so same-cycle releases
  // never unblock issue and no path exists from iss_fire_i back to stall_o.
  always_comb begin
    vd_m     = iss_use_i[0] ? grp_mask(iss_vd_i,  iss_emul_i) : '0;
    vs1_m    = iss_use_i[1] ? grp_mask(iss_vs1_i, iss_emul_i) : '0;
    vs2_m    = iss_use_i[2] ? grp_mask(iss_vs2_i, iss_emul_i) : '0;
    rd_nz    = '0;
    full_vec = '0;
    for (int r = 0; r < NrVReg; r++) begin
      rd_nz[r]    = |readers_q[r];
      full_vec[r] = (int'(readers_q[r]) + int'(vs1_m[r]) + int'(vs2_m[r])) > CntMax;
    end
    cause[0] = |(vd_m & writing_q);
    cause[1] = |(vd_m & rd_nz);
    cause[2] = |(vs1_m & writing_q);
    cause[3] = |(vs2_m & writing_q);
    cause[4] = |full_vec;
  end

  always_comb begin
    int cnt;
    int dec;
    cnt         = 0;
    dec         = 0;
    writing_d   = writing_q;
    writer_id_d = writer_id_q;
    readers_d   = readers_q;
    err_d       = err_q;

    for (int q = 0; q < NrOpQueue; q++) begin
      rel_m[q] = rd_done_i[q] ? grp_mask(rd_vs_i[q], rd_emul_i[q]) : '0;
    end
    for (int c = 0; c < NrVFU; c++) begin
      cpl_m[c] = wr_done_i[c] ? grp_mask(wr_vd_i[c], wr_emul_i[c]) : '0;
    end

    // Releases are applied before issue increments; both clamp.
    for (int r = 0; r < NrVReg; r++) begin
      dec = 0;
      for (int q = 0; q < NrOpQueue; q++) begin
        if (rel_m[q][r]) dec = dec + 1;
      end
      cnt = int'(readers_q[r]) - dec;
      if (cnt < 0) begin
        cnt   = 0;
        err_d = 1'b1;
      end
      if (iss_fire_i) cnt = cnt + int'(vs1_m[r]) + int'(vs2_m[r]);
      if (cnt > CntMax) cnt = CntMax;
      readers_d[r] = ReaderCntW'(cnt);
    end

    for (int c = 0; c < NrVFU; c++) begin
      for (int r = 0; r < NrVReg; r++) begin
        if (cpl_m[c][r]) begin
          if (writing_q[r] && (writer_id_q[r] == wr_id_i[c])) writing_d[r] = 1'b0;
          else err_d = 1'b1;
        end
      end
    end

    // Issue lands after completion so a same-cycle reissue keeps the register
    // marked as written, now owned by the new ID.
    if (iss_fire_i) begin
      if (stall_o) err_d = 1'b1;
      for (int r = 0; r < NrVReg; r++) begin
        if (vd_m[r]) begin
          writing_d[r]   = 1'b1;
          writer_id_d[r] = iss_id_i;
        end
      end
    end

    // err_q deliberately survives a flush.
    if (flush_i) begin
      writing_d   = '0;
      writer_id_d = '0;
      readers_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      writing_q   <= '0;
      writer_id_q <= '0;
      readers_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      writing_q   <= writing_d;
      writer_id_q <= writer_id_d;
      readers_q   <= readers_d;
      err_q       <= err_d;
    end
  end

  assign stall_cause_o = cause;
  assign stall_o       = |cause;
  assign busy_o        = (|writing_q) | (|rd_nz);
  assign err_o         = err_q;

endmodule

// File: tb/tb_vreg_group_scoreboard.sv
module tb_vreg_group_scoreboard;

  localparam logic [4:0] C_W   = 5'b00001;
  localparam logic [4:0] C_WAR = 5'b00010;
  localparam logic [4:0] C_R1  = 5'b00100;
  localparam logic [4:0] C_R2  = 5'b01000;
  localparam logic [4:0] C_F   = 5'b10000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      iss_use = '0;
  logic [4:0]      iss_vd = '0, iss_vs1 = '0, iss_vs2 = '0;
  logic [1:0]      iss_emul = '0;
  logic [2:0]      iss_id = '0;
  logic            iss_fire = 1'b0;
  logic [3:0]      rd_done = '0;
  logic [3:0][4:0] rd_vs = '0;
  logic [3:0][1:0] rd_emul = '0;
  logic [3:0]      wr_done = '0;
  logic [3:0][4:0] wr_vd = '0;
  logic [3:0][1:0] wr_emul = '0;
  logic [3:0][2:0] wr_id = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic [4:0]      cause;
  logic            busy;
  logic            err;

  vreg_group_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_n),
    .iss_use_i(iss_use), .iss_vd_i(iss_vd), .iss_vs1_i(iss_vs1), .iss_vs2_i(iss_vs2),
    .iss_emul_i(iss_emul), .iss_id_i(iss_id), .iss_fire_i(iss_fire),
    .rd_done_i(rd_done), .rd_vs_i(rd_vs), .rd_emul_i(rd_emul),
    .wr_done_i(wr_done), .wr_vd_i(wr_vd), .wr_emul_i(wr_emul), .wr_id_i(wr_id),
    .flush_i(flush),
    .stall_o(stall), .stall_cause_o(cause), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic [4:0] cause;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: outputs are sampled on the falling edge, away from the updates.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall || cause !== e.cause || busy !== e.busy || err !== e.err) begin
        errors++;
        $display("FAIL %s: got stall=%0b cause=%05b busy=%0b err=%0b, want stall=%0b cause=%05b busy=%0b err=%0b",
                 e.name, stall, cause, busy, err, e.stall, e.cause, e.busy, e.err);
      end
    end
  end

  task automatic chk(input string n, input logic s, input logic [4:0] c,
                     input logic b, input logic e);
    exp_t x;
    x.name = n; x.stall = s; x.cause = c; x.busy = b; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    iss_fire = 1'b0;
    rd_done  = '0;
    wr_done  = '0;
    flush    = 1'b0;
  endtask

  task automatic iss(input logic [2:0] u, input int vd, input int vs1, input int vs2,
                     input int emul, input int id, input logic fire);
    iss_use  = u;
    iss_vd   = 5'(vd);
    iss_vs1  = 5'(vs1);
    iss_vs2  = 5'(vs2);
    iss_emul = 2'(emul);
    iss_id   = 3'(id);
    iss_fire = fire;
  endtask

  task automatic rd(input int ch, input int vs, input int emul);
    rd_done[ch] = 1'b1;
    rd_vs[ch]   = 5'(vs);
    rd_emul[ch] = 2'(emul);
  endtask

  task automatic wr(input int ch, input int vd, input int emul, input int id);
    wr_done[ch] = 1'b1;
    wr_vd[ch]   = 5'(vd);
    wr_emul[ch] = 2'(emul);
    wr_id[ch]   = 3'(id);
  endtask

  initial begin
    #1;
    chk("reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // RAW on a group member, cleared by completion one cycle later
    iss(3'b001, 8, 0, 0, 2, 3, 1);  chk("t1_issue", 0, 0, 0, 0);           tick();
    iss(3'b010, 0, 10, 0, 0, 0, 0); chk("t1_raw_vs1", 1, C_R1, 1, 0);      tick();
    iss(3'b100, 0, 0, 11, 0, 0, 0); chk("t1_raw_vs2", 1, C_R2, 1, 0);      tick();
    iss(3'b001, 7, 0, 0, 1, 0, 0);  chk("t1_waw_overlap", 1, C_W, 1, 0);   tick();
    iss(3'b010, 0, 10, 0, 0, 0, 0); wr(0, 8, 2, 3);
    chk("t1_cpl_same_cycle", 1, C_R1, 1, 0);                               tick();
    chk("t1_released", 0, 0, 0, 0);                                        tick();

    // Reader counter capacity on v4
    iss(3'b010, 0, 4, 0, 0, 0, 1);  chk("t2_rd1", 0, 0, 0, 0);             tick();
    iss(3'b010, 0, 4, 0, 0, 0, 1);  chk("t2_rd2", 0, 0, 1, 0);             tick();
    iss(3'b010, 0, 4, 0, 0, 0, 1);  chk("t2_rd3", 0, 0, 1, 0);             tick();
    iss(3'b110, 0, 4, 4, 0, 0, 0);  chk("t2_full", 1, C_F, 1, 0);          tick();
    iss(3'b001, 4, 0, 0, 0, 0, 0);  chk("t2_war", 1, C_WAR, 1, 0);         tick();
    iss(3'b110, 0, 4, 4, 0, 0, 0);  rd(0, 4, 0);
    chk("t2_rel_same_cycle", 1, C_F, 1, 0);                                tick();
    chk("t2_still_full", 1, C_F, 1, 0);                                    tick();
    rd(0, 4, 0); rd(1, 4, 0);       chk("t2_dual_rel", 1, C_F, 1, 0);      tick();
    iss(3'b110, 0, 4, 4, 0, 0, 1);  chk("t2_fourth", 0, 0, 0, 0);          tick();
    iss(3'b001, 4, 0, 0, 0, 0, 0);  chk("t2_war_two", 1, C_WAR, 1, 0);     tick();
    iss(3'b010, 0, 4, 0, 0, 0, 0);  chk("t2_room_one", 0, 0, 1, 0);        tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  rd(0, 4, 0); rd(1, 4, 0);
    chk("t2_clean", 0, 0, 1, 0);                                           tick();
    chk("t2_idle", 0, 0, 0, 0);                                            tick();

    // No same-cycle bypass of a release
    iss(3'b110, 0, 5, 5, 0, 0, 1);  chk("t3_fill2", 0, 0, 0, 0);           tick();
    iss(3'b010, 0, 5, 0, 0, 0, 1);  chk("t3_fill3", 0, 0, 1, 0);           tick();
    iss(3'b010, 0, 5, 0, 0, 0, 0);  rd(0, 5, 0);
    chk("t3_no_bypass", 1, C_F, 1, 0);                                     tick();
    chk("t3_unblocked", 0, 0, 1, 0);                                       tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  rd(0, 5, 0); rd(1, 5, 0);
    chk("t3_clean", 0, 0, 1, 0);                                           tick();
    chk("t3_idle", 0, 0, 0, 0);                                            tick();

    // Group truncated at the top of the register file
    iss(3'b001, 30, 0, 0, 2, 2, 1); chk("t4_issue", 0, 0, 0, 0);           tick();
    iss(3'b010, 0, 0, 0, 0, 0, 0);  chk("t4_v0_free", 0, 0, 1, 0);         tick();
    iss(3'b010, 0, 29, 0, 0, 0, 0); chk("t4_v29_free", 0, 0, 1, 0);        tick();
    iss(3'b010, 0, 31, 0, 0, 0, 0); chk("t4_v31_raw", 1, C_R1, 1, 0);      tick();
    iss(3'b100, 0, 0, 30, 0, 0, 0); chk("t4_v30_raw", 1, C_R2, 1, 0);      tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  wr(0, 30, 2, 2);
    chk("t4_cpl", 0, 0, 1, 0);                                             tick();
    chk("t4_idle_no_err", 0, 0, 0, 0);                                     tick();

    // Wrong-ID completion, sticky error, flush
    iss(3'b001, 2, 0, 0, 0, 1, 1);  chk("t5_issue", 0, 0, 0, 0);           tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  wr(2, 2, 0, 5);
    chk("t5_bad_id", 0, 0, 1, 0);                                          tick();
    iss(3'b010, 0, 2, 0, 0, 0, 0);  chk("t5_still_writing", 1, C_R1, 1, 1); tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  flush = 1'b1;
    chk("t5_flush", 0, 0, 1, 1);                                           tick();
    chk("t5_after_flush", 0, 0, 0, 1);                                     tick();
    rd(3, 9, 0);                    chk("t5_underflow", 0, 0, 0, 1);       tick();
    chk("t5_clamped", 0, 0, 0, 1);                                         tick();

    // Completion and reissue of v6 in the same cycle
    iss(3'b001, 6, 0, 0, 0, 1, 1);  chk("t6_issue", 0, 0, 0, 1);           tick();
    iss(3'b001, 6, 0, 0, 0, 4, 1);  wr(1, 6, 0, 1);
    chk("t6_simul", 1, C_W, 1, 1);                                         tick();
    iss(3'b010, 0, 6, 0, 0, 0, 0);  chk("t6_writing", 1, C_R1, 1, 1);      tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  wr(1, 6, 0, 4);
    chk("t6_cpl_new_id", 0, 0, 1, 1);                                      tick();
    chk("t6_idle", 0, 0, 0, 1);                                            tick();

    // Asynchronous reset mid-operation
    iss(3'b001, 12, 0, 0, 0, 2, 1); chk("t7_issue", 0, 0, 0, 1);           tick();
    iss(3'b000, 0, 0, 0, 0, 0, 0);  chk("t7_busy", 0, 0, 1, 1);            tick();
    rst_n = 1'b0;                   chk("t7_in_reset", 0, 0, 0, 0);        tick();
    rst_n = 1'b1;                   chk("t7_post_reset", 0, 0, 0, 0);      tick();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vreg_group_scoreboard.md
# vreg_group_scoreboard

Parametrised vector-register hazard scoreboard placed between the decoder/launcher and the VFU/operand-queue back end. It tracks outstanding writers and readers per architectural vector register and raises a combinational stall on WAW, WAR and RAW hazards. Unlike the previous single-register scoreboard, it handles LMUL register groups, saturating reader counters with a capacity stall, per-register writer-ID checking, flush, and sticky error reporting.

## Interface
- NrVReg, 32, number of architectural vector registers (power of two).
- NrVFU, 4, number of writeback-completion channels.
- NrOpQueue, 4, number of operand-queue read-release channels.
- ReaderCntW, 2, reader counter width; max readers per register = 2^ReaderCntW-1.
- IdW, 3, instruction ID width.
- MaxEmulLog, 3, largest log2 register-group size accepted.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- iss_use_i  in  3  use flags {vs2, vs1, vd}.
- iss_vd_i / iss_vs1_i / iss_vs2_i  in  log2(NrVReg) each  group base registers.
- iss_emul_i  in  log2(MaxEmulLog+1)  log2 group size, shared by all three operands.
- iss_id_i  in  IdW  instruction ID.
- iss_fire_i  in  1  instruction was issued this cycle; commit the state update.
- rd_done_i  in  NrOpQueue  read release, one per queue.
- rd_vs_i, rd_emul_i  in  per queue  released group.
- wr_done_i  in  NrVFU  writeback complete.
- wr_vd_i, wr_emul_i, wr_id_i  in  per VFU  completed group and its ID.
- flush_i  in  1  synchronous clear of all tracking state.
- stall_o  out  1  issue must not fire.
- stall_cause_o  out  5  {cnt_full, raw_vs2, raw_vs1, war, waw}.
- busy_o  out  1  any writing bit set or any reader count nonzero.
- err_o  out  1  sticky protocol error.

## Operation
- Group mask of (base, emul): registers base .. base+2^emul-1. Registers at or above NrVReg are dropped with no wrap. emul > MaxEmulLog is treated as MaxEmulLog.
- State per register: writing_q (1b), writer_id_q (IdW), readers_q (ReaderCntW). All are zero on reset and on flush_i.
- Stall causes, each evaluated over the full group mask and only for the used operands:
  - waw: vd group ∩ writing_q.
  - war: vd group ∩ (readers_q≠0).
  - raw_vs1 / raw_vs2: source group ∩ writing_q.
  - cnt_full: some register with readers_q + inc > max, where inc = [vs1 covers r] + [vs2 covers r] (0..2).
- stall_o is the OR of all causes. It depends only on iss_* inputs and the _q state, never on iss_fire_i or on same-cycle releases, so no combinational loop exists.
- Commit on iss_fire_i:
  - Set writing and writer_id for every register in the vd group.
  - Add inc to readers of every source-group register.
  - iss_fire_i while stall_o=1 sets err_o; the update is still applied, with counters saturating.
- Read release: each rd_done_i decrements every register in its group by 1. Multiple channels on the same register in one cycle sum their decrements. Any decrement below 0 clamps to 0 and sets err_o.
- Write completion: clears writing for each register in the group whose writer_id_q == wr_id_i. If writing_q=0 or the ID mismatches, that register is unchanged and err_o is set.
- Same-cycle ordering:
  - readers_d = readers_q − releases + issue increments.
  - A writing bit cleared by completion and set by issue in the same cycle ends set, with the new ID.
- flush_i has priority over all same-cycle updates. It does not clear err_o; only reset clears err_o.

## Timing
- Reset values: stall_o=0, stall_cause_o=0, busy_o=0, err_o=0.
- stall_o and stall_cause_o are combinational, valid in the same cycle as the iss_* fields.
- State updates land at the next clk_i edge. A release in cycle N unblocks a stall in cycle N+1, never in cycle N.
- busy_o is registered-state derived: it is 0 the cycle after flush_i.
- Reset asserted mid-operation clears all state asynchronously. No pending release is replayed.

## Test plan
- Issue vd=8, emul=2 (v8–v11), id=3. Next cycle present vs1=10, emul=0 -> stall_o=1, cause=raw_vs1. Then wr_done vd=8, emul=2, id=3 -> stall_o=0 the cycle after.
- ReaderCntW=2: issue three instructions reading v4, then a fourth with vs1=vs2=v4 -> cnt_full=1. Then one rd_done on v4 -> readers=2, and the fourth still stalls (2+2>3). After two more releases, readers=0 and the fourth issues, leaving readers_q[v4]=2.
- Same cycle: rd_done releases v5 while a new issue reads v5 with readers_q=3 -> stall_o=1 (no same-cycle bypass). Next cycle readers=2 -> stall_o=0.
- Group at edge: vd=30, emul=2 -> only v30 and v31 set. v0 is untouched and a read of v0 does not stall.
- Wrong-ID completion: v2 written by id=1, wr_done id=5 -> writing stays 1 and err_o=1 sticky. Then flush_i -> busy_o=0 next cycle, while err_o stays 1.
- Simultaneous completion and reissue on v6: v6 ends writing=1 with writer_id = the new ID.
